btn_conditioner: RTL



---
 rtl/btn_conditioner.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/btn_conditioner.sv
// btn_conditioner: front end between raw board inputs and the game FSM.
//
// Each of the five push buttons is synchronised and then debounced by its own
// four-state FSM. A debounced press raises a one-cycle request. When several
// requests arrive in the same cycle, a fixed-priority arbiter passes only the
// lowest-indexed one to btn_pulse; the others are dropped.
// The nine card switches are synchronised, registered onto card_sel, and
// decoded into a one-hot validity flag and an encoded index.
//
// Optional feature: define BTN_AUTOREPEAT_EN to enable auto-repeat. A held
// button then issues a further request every REPEAT_CYCLES cycles.
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-high reset
//   btn_raw     raw buttons (0 center, 1 top, 2 bottom, 3 left, 4 right)
//   sw_raw      raw card switches
//   btn_pulse   single-cycle press pulses, at most one bit high per cycle
//   btn_level   debounced held level per button
//   card_sel    synchronised switch bus
//   card_valid  exactly one card_sel bit set
//   card_index  index of the set bit, 4'hF when card_valid is low
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] btn_raw,
  input  logic [8:0] sw_raw,
  output logic [4:0] btn_pulse,
  output logic [4:0] btn_level,
  output logic [8:0] card_sel,
  output logic       card_valid,
  output logic [3:0] card_index
);

  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] PRESS_WAIT   = 2'd1;
  localparam logic [1:0] HELD         = 2'd2;
  localparam logic [1:0] RELEASE_WAIT = 2'd3;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES out of range for CNT_W");
  end
  if (REPEAT_CYCLES < 1) begin : g_bad_repeat
    $error("REPEAT_CYCLES must be at least 1");
  end

  logic [4:0] btn_s1, btn_s2;
  logic [8:0] sw_s1, sw_s2;

  logic [1:0]       state     [5];
  logic [1:0]       state_nxt [5];
  logic [CNT_W-1:0] cnt       [5];
  logic [CNT_W-1:0] cnt_nxt   [5];
  logic [4:0]       req;
  logic [4:0]       level_nxt;
  logic [4:0]       grant;

`ifdef BTN_AUTOREPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);
  localparam logic [RPT_W-1:0] RPT_ONE  = 1;

  logic [RPT_W-1:0] rcnt     [5];
  logic [RPT_W-1:0] rcnt_nxt [5];
`endif

  logic [3:0] sw_ones;
  logic [3:0] sw_idx;
  logic       sw_onehot;

  // Two-flop synchronisers; only the second stage is used downstream.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_s1 <= '0;
      btn_s2 <= '0;
      sw_s1  <= '0;
      sw_s2  <= '0;
    end else begin
      btn_s1 <= btn_raw;
      btn_s2 <= btn_s1;
      sw_s1  <= sw_raw;
      sw_s2  <= sw_s1;
    end
  end

  // Per-button debounce FSMs.
  always_comb begin
    req       = '0;
    level_nxt = '0;
    for (int unsigned k = 0; k < 5; k++) begin
      state_nxt[k] = state[k];
      cnt_nxt[k]   = cnt[k];
      case (state[k])
        IDLE: begin
          if (btn_s2[k]) begin
            state_nxt[k] = PRESS_WAIT;
            cnt_nxt[k]   = '0;
          end
        end
        PRESS_WAIT: begin
          if (!btn_s2[k]) begin
            state_nxt[k] = IDLE;
          end else if (cnt[k] == DB_LAST) begin
            state_nxt[k] = HELD;
            req[k]       = 1'b1;
          end else begin
            cnt_nxt[k] = cnt[k] + CNT_ONE;
          end
        end
        HELD: begin
          if (!btn_s2[k]) begin
            state_nxt[k] = RELEASE_WAIT;
            cnt_nxt[k]   = '0;
          end
        end
        RELEASE_WAIT: begin
          if (btn_s2[k]) begin
            state_nxt[k] = HELD;
          end else if (cnt[k] == DB_LAST) begin
            state_nxt[k] = IDLE;
          end else begin
            cnt_nxt[k] = cnt[k] + CNT_ONE;
          end
        end
        default: state_nxt[k] = IDLE;
      endcase
`ifdef BTN_AUTOREPEAT_EN
      // Repeat counter only runs while stably held; anything else clears it.
      rcnt_nxt[k] = '0;
      if (state[k] == HELD && btn_s2[k]) begin
        if (rcnt[k] == RPT_LAST) begin
          req[k] = 1'b1;
        end else begin
          rcnt_nxt[k] = rcnt[k] + RPT_ONE;
        end
      end
`endif
      // Level is registered from the next state so it rises with the pulse.
      level_nxt[k] = (state_nxt[k] == HELD) || (state_nxt[k] == RELEASE_WAIT);
    end
  end

  // Fixed priority: isolate the lowest set request bit.
  assign grant = req & (~req + 5'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned k = 0; k < 5; k++) begin
        state[k] <= IDLE;
        cnt[k]   <= '0;
`ifdef BTN_AUTOREPEAT_EN
        rcnt[k]  <= '0;
`endif
      end
      btn_pulse <= '0;
      btn_level <= '0;
    end else begin
      for (int unsigned k = 0; k < 5; k++) begin
        state[k] <= state_nxt[k];
        cnt[k]   <= cnt_nxt[k];
`ifdef BTN_AUTOREPEAT_EN
        rcnt[k]  <= rcnt_nxt[k];
`endif
      end
      btn_pulse <= grant;
      btn_level <= level_nxt;
    end
  end

  // Card decode from the same synchronised sample that feeds card_sel.
  always_comb begin
    sw_ones = '0;
    sw_idx  = 4'hF;
    for (int unsigned i = 0; i < 9; i++) begin
      if (sw_s2[i]) begin
        sw_ones = sw_ones + 4'd1;
        sw_idx  = 4'(i);
      end
    end
    sw_onehot = (sw_ones == 4'd1);
    if (!sw_onehot) begin
      sw_idx = 4'hF;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      card_sel   <= '0;
      card_valid <= 1'b0;
      card_index <= 4'hF;
    end else begin
      card_sel   <= sw_s2;
      card_valid <= sw_onehot;
      card_index <= sw_idx;
    end
  end

endmodule
